// File: rtl/clk_div_checker_pkg.sv
// rtl/clk_div_checker_pkg.sv - shared state encodings and parameter defaults for the divided-clock checker
package clk_div_checker_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ARM  = 2'd1;
    localparam state_t ST_MEAS = 2'd2;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_EXP_PERIOD = 9;
    localparam int DEF_HIGH_MIN   = 4;
    localparam int DEF_HIGH_MAX   = 5;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_TIMEOUT    = 32;

endpackage

// File: rtl/clk_div_checker_edge_sync.sv
// rtl/clk_div_checker_edge_sync.sv - two-flop synchroniser plus delay flop giving level, rise and fall
module edge_sync (
    input  logic clk,
    input  logic rstn,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronise the asynchronous input, then keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/clk_div_checker.sv
// rtl/clk_div_checker.sv - measures period and high time of a divided clock and flags lock, period errors and stuck clock
module clk_div_checker
    import clk_div_checker_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int HIGH_MIN   = DEF_HIGH_MIN,
    parameter int HIGH_MAX   = DEF_HIGH_MAX,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clk_in,
    input  logic             en,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_vld,
    output logic             locked,
    output logic             err_period,
    output logic             err_stuck
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  EXP_P     = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0]  HI_MIN    = CNT_W'(HIGH_MIN);
    localparam logic [CNT_W-1:0]  HI_MAX    = CNT_W'(HIGH_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LIM  = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

    logic sync_level;
    logic sync_rise;
    logic sync_fall;

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  per_cnt_q,  per_cnt_d;
    logic [CNT_W-1:0]  hi_cnt_q,   hi_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]  period_q,   period_d;
    logic [CNT_W-1:0]  high_q,     high_d;
    logic              vld_q,      vld_d;
    logic              err_per_q,  err_stk_q;
    logic              set_per;
    logic              set_stuck;
    logic              meas_good;
    logic [IDLE_W-1:0] idle_inc;

    edge_sync u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .async_i (clk_in),
        .level_o (sync_level),
        .rise_o  (sync_rise),
        .fall_o  (sync_fall)
    );

    // A saturated period never matches, even if the expected period happens to be all-ones
    assign meas_good = (per_cnt_q == EXP_P) && (per_cnt_q != CNT_MAX) &&
                       (hi_cnt_q >= HI_MIN) && (hi_cnt_q <= HI_MAX);
    assign idle_inc  = idle_cnt_q + IDLE_ONE;

    // Next-state for FSM, counters, measurement registers and error set events
    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        idle_cnt_d = idle_cnt_q;
        good_cnt_d = good_cnt_q;
        period_d   = period_q;
        high_d     = high_q;
        vld_d      = 1'b0;
        set_per    = 1'b0;
        set_stuck  = 1'b0;
        if (!en) begin
            state_d    = ST_IDLE;
            per_cnt_d  = '0;
            hi_cnt_d   = '0;
            idle_cnt_d = '0;
            good_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ARM;
                    per_cnt_d  = '0;
                    hi_cnt_d   = '0;
                    idle_cnt_d = '0;
                    good_cnt_d = '0;
                end
                ST_ARM, ST_MEAS: begin
                    idle_cnt_d = (sync_rise || sync_fall) ? '0 : idle_inc;
                    if (sync_rise) begin
                        state_d   = ST_MEAS;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        // The rise that ends ARM only starts the first period
                        if (state_q == ST_MEAS) begin
                            vld_d    = 1'b1;
                            period_d = per_cnt_q;
                            high_d   = hi_cnt_q;
                            if (meas_good) begin
                                if (good_cnt_q != GOOD_LIM) begin
                                    good_cnt_d = good_cnt_q + GOOD_ONE;
                                end
                            end else begin
                                set_per    = 1'b1;
                                good_cnt_d = '0;
                            end
                        end
                    end else if (idle_inc == IDLE_LIM) begin
                        set_stuck  = 1'b1;
                        state_d    = ST_ARM;
                        idle_cnt_d = '0;
                        per_cnt_d  = '0;
                        hi_cnt_d   = '0;
                        good_cnt_d = '0;
                    end else if (state_q == ST_MEAS) begin
                        if (per_cnt_q != CNT_MAX) begin
                            per_cnt_d = per_cnt_q + CNT_ONE;
                        end
                        if (sync_level && (hi_cnt_q != CNT_MAX)) begin
                            hi_cnt_d = hi_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    per_cnt_d  = '0;
                    hi_cnt_d   = '0;
                    idle_cnt_d = '0;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    // State, counter and measurement registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            idle_cnt_q <= '0;
            good_cnt_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            good_cnt_q <= good_cnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            vld_q      <= vld_d;
        end
    end

    // Sticky error flags; a set event in the same cycle as clr_err wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_per_q <= 1'b0;
            err_stk_q <= 1'b0;
        end else begin
            err_per_q <= set_per   | (err_per_q & ~clr_err);
            err_stk_q <= set_stuck | (err_stk_q & ~clr_err);
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_vld   = vld_q;
    assign locked     = (good_cnt_q == GOOD_LIM);
    assign err_period = err_per_q;
    assign err_stuck  = err_stk_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// tb/tb_clk_div_checker.sv - self-checking bench for clk_div_checker
module tb_clk_div_checker;

    localparam int CNT_W      = 8;
    localparam int EXP_PERIOD = 9;
    localparam int HIGH_MIN   = 4;
    localparam int HIGH_MAX   = 5;
    localparam int LOCK_CNT   = 4;
    localparam int TIMEOUT    = 32;
    localparam int SYNC_LAT   = 3;

    logic clk = 1'b0;
    logic rstn, clk_in, en, clr_err;
    logic [CNT_W-1:0] period, high_time;
    logic meas_vld, locked, err_period, err_stuck;

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] h;
        logic       lk;
        logic       ep;
    } meas_t;

    meas_t obs_q[$];
    meas_t exp_q[$];
    int    run_m;
    logic  err_m;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    dbl_vld = 0;
    logic  vld_prev = 1'b0;

    clk_div_checker #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .HIGH_MIN(HIGH_MIN),
        .HIGH_MAX(HIGH_MAX), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .clk_in(clk_in), .en(en), .clr_err(clr_err),
        .period(period), .high_time(high_time), .meas_vld(meas_vld),
        .locked(locked), .err_period(err_period), .err_stuck(err_stuck)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (meas_vld) obs_q.push_back(meas_t'{p: period, h: high_time, lk: locked, ep: err_period});
        if (meas_vld && vld_prev) dbl_vld++;
        vld_prev = meas_vld;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each completed waveform period yields one measurement judged by the lock/error rules
    function automatic void model_period(input int h, input int l);
        meas_t m;
        int    p;
        bit    good;
        p = h + l;
        good = (p == EXP_PERIOD) && (h >= HIGH_MIN) && (h <= HIGH_MAX) && (p < 255);
        if (good) begin
            if (run_m < LOCK_CNT) run_m++;
        end else begin
            run_m = 0;
            err_m = 1'b1;
        end
        m.p  = 8'(p);
        m.h  = 8'(h);
        m.lk = (run_m == LOCK_CNT);
        m.ep = err_m;
        exp_q.push_back(m);
    endfunction

    task automatic drive_waves(input int hs[$], input int ls[$]);
        foreach (hs[i]) begin
            clk_in = 1'b1;
            repeat (hs[i]) step();
            clk_in = 1'b0;
            repeat (ls[i]) step();
            model_period(hs[i], ls[i]);
        end
        clk_in = 1'b1;
        repeat (4) step();
    endtask

    task automatic rearm();
        clk_in = 1'b0;
        en = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        repeat (3) step();
        en = 1'b1;
        run_m = 0;
        err_m = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; clk_in = 1'b0; clr_err = 1'b0;
        repeat (3) step();
        n_cmp++; if (period !== 8'd0) begin n_bad++; $display("FAIL reset_period: got %0d want 0", period); end
        n_cmp++; if (high_time !== 8'd0) begin n_bad++; $display("FAIL reset_high: got %0d want 0", high_time); end
        n_cmp++; if (meas_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", meas_vld); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (err_period !== 1'b0) begin n_bad++; $display("FAIL reset_err_period: got %b want 0", err_period); end
        n_cmp++; if (err_stuck !== 1'b0) begin n_bad++; $display("FAIL reset_err_stuck: got %b want 0", err_stuck); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_clean_lock();
        int hs[$], ls[$];
        meas_t o, e;
        rearm();
        repeat (6) begin hs.push_back(4); ls.push_back(5); end
        drive_waves(hs, ls);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL clean_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL clean_meas: got p=%0d h=%0d lk=%b ep=%b want p=%0d h=%0d lk=%b ep=%b", o.p, o.h, o.lk, o.ep, e.p, e.h, e.lk, e.ep); end
        end
    endtask

    task automatic test_bad_after_lock();
        int hs[$], ls[$];
        meas_t o, e;
        rearm();
        repeat (4) begin hs.push_back(4); ls.push_back(5); end
        hs.push_back(4); ls.push_back(6);
        repeat (4) begin hs.push_back(4); ls.push_back(5); end
        drive_waves(hs, ls);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL badlock_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL badlock_meas: got p=%0d h=%0d lk=%b ep=%b want p=%0d h=%0d lk=%b ep=%b", o.p, o.h, o.lk, o.ep, e.p, e.h, e.lk, e.ep); end
        end
    endtask

    task automatic test_random();
        int hs[$], ls[$];
        meas_t o, e;
        rearm();
        repeat (16) begin
            if ($urandom_range(0, 2) == 0) begin
                hs.push_back(int'($urandom_range(2, 7)));
                ls.push_back(int'($urandom_range(2, 8)));
            end else begin
                hs.push_back(4); ls.push_back(5);
            end
        end
        drive_waves(hs, ls);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL random_meas: got p=%0d h=%0d lk=%b ep=%b want p=%0d h=%0d lk=%b ep=%b", o.p, o.h, o.lk, o.ep, e.p, e.h, e.lk, e.ep); end
        end
    endtask

    task automatic test_stuck();
        int hs[$], ls[$];
        meas_t o, e;
        rearm();
        repeat (5) begin hs.push_back(4); ls.push_back(5); end
        drive_waves(hs, ls);
        obs_q.delete(); exp_q.delete();
        clk_in = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == SYNC_LAT + TIMEOUT - 1) begin
                n_cmp++; if (err_stuck !== 1'b0) begin n_bad++; $display("FAIL stuck_early: got %b want 0 at k=%0d", err_stuck, k); end
                n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL stuck_prelock: got %b want 1", locked); end
            end
            if (k == SYNC_LAT + TIMEOUT) begin
                n_cmp++; if (err_stuck !== 1'b1) begin n_bad++; $display("FAIL stuck_set: got %b want 1 at k=%0d", err_stuck, k); end
                n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL stuck_unlock: got %b want 0", locked); end
            end
        end
        run_m = 0;
        hs.delete(); ls.delete();
        repeat (4) begin hs.push_back(4); ls.push_back(5); end
        drive_waves(hs, ls);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL restart_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL restart_meas: got p=%0d h=%0d lk=%b ep=%b want p=%0d h=%0d lk=%b ep=%b", o.p, o.h, o.lk, o.ep, e.p, e.h, e.lk, e.ep); end
        end
        n_cmp++; if (err_stuck !== 1'b1) begin n_bad++; $display("FAIL stuck_sticky: got %b want 1", err_stuck); end
    endtask

    task automatic test_clr_err();
        clk_in = 1'b0;
        repeat (5) step();
        clk_in = 1'b1;
        repeat (6) step();
        clk_in = 1'b0;
        repeat (3) step();
        clk_in = 1'b1;
        repeat (4) step();
        n_cmp++; if (err_period !== 1'b1 || err_stuck !== 1'b1) begin n_bad++; $display("FAIL clr_pre: got ep=%b es=%b want 1 1", err_period, err_stuck); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_cmp++; if (err_period !== 1'b0 || err_stuck !== 1'b0) begin n_bad++; $display("FAIL clr_alone: got ep=%b es=%b want 0 0", err_period, err_stuck); end
        clk_in = 1'b0;
        repeat (5) step();
        clk_in = 1'b1;
        repeat (6) step();
        clk_in = 1'b0;
        repeat (3) step();
        clk_in = 1'b1;
        repeat (2) step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_cmp++; if (meas_vld !== 1'b1 || high_time !== 8'd6) begin n_bad++; $display("FAIL clr_coinc_meas: got vld=%b h=%0d want 1 6", meas_vld, high_time); end
        n_cmp++; if (err_period !== 1'b1) begin n_bad++; $display("FAIL clr_coinc_set_wins: got %b want 1", err_period); end
    endtask

    task automatic test_en_drop();
        int hs[$], ls[$];
        meas_t o, e;
        rearm();
        repeat (4) begin hs.push_back(4); ls.push_back(5); end
        drive_waves(hs, ls);
        obs_q.delete(); exp_q.delete();
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL en_prelock: got %b want 1", locked); end
        en = 1'b0;
        step();
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL en_unlock: got %b want 0", locked); end
        n_cmp++; if (period !== 8'd9) begin n_bad++; $display("FAIL en_period_hold: got %0d want 9", period); end
        clk_in = 1'b0;
        repeat (3) step();
        en = 1'b1;
        run_m = 0;
        hs.delete(); ls.delete();
        hs.push_back(4); ls.push_back(5);
        drive_waves(hs, ls);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL en_rearm_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL en_rearm_meas: got p=%0d h=%0d lk=%b ep=%b want p=%0d h=%0d lk=%b ep=%b", o.p, o.h, o.lk, o.ep, e.p, e.h, e.lk, e.ep); end
        end
    endtask

    task automatic test_reset_mid();
        int hs[$], ls[$];
        meas_t o, e;
        rearm();
        repeat (4) begin hs.push_back(4); ls.push_back(5); end
        drive_waves(hs, ls);
        step();
        rstn = 1'b0;
        #1;
        n_cmp++; if (period !== 8'd0 || high_time !== 8'd0 || locked !== 1'b0 || meas_vld !== 1'b0 || err_period !== 1'b0 || err_stuck !== 1'b0)
            begin n_bad++; $display("FAIL rst_mid: got p=%0d h=%0d lk=%b vld=%b ep=%b es=%b want all 0", period, high_time, locked, meas_vld, err_period, err_stuck); end
        clk_in = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();
        run_m = 0; err_m = 1'b0;
        obs_q.delete(); exp_q.delete();
        hs.delete(); ls.delete();
        repeat (2) begin hs.push_back(6); ls.push_back(3); end
        drive_waves(hs, ls);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rst_post_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL rst_post_meas: got p=%0d h=%0d lk=%b ep=%b want p=%0d h=%0d lk=%b ep=%b", o.p, o.h, o.lk, o.ep, e.p, e.h, e.lk, e.ep); end
        end
    endtask

    task automatic test_single_pulse();
        n_cmp++; if (dbl_vld != 0) begin n_bad++; $display("FAIL vld_back_to_back: got %0d want 0", dbl_vld); end
    endtask

    initial begin
        run_m = 0;
        err_m = 1'b0;
        test_reset();
        test_clean_lock();
        test_bad_after_lock();
        test_random();
        test_stuck();
        test_clr_err();
        test_en_drop();
        test_reset_mid();
        test_single_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
